// File: rtl/pipe_dest_tracker.sv
// Destination-register tracker for the EX/MEM/WB pipeline registers.
// Publishes per-stage dest/wreg/m2reg for forwarding, detects load-use
// hazards (stall plus EX bubble) and counts retired instructions.
module pipe_dest_tracker #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dvalid,
  input  logic             dwreg,
  input  logic             dm2reg,
  input  logic             dwmem,
  input  logic             dregrt,
  input  logic [REG_W-1:0] drs,
  input  logic [REG_W-1:0] drt,
  input  logic [REG_W-1:0] drd,
  output logic [REG_W-1:0] edestReg,
  output logic             ewreg,
  output logic             em2reg,
  output logic [REG_W-1:0] mdestReg,
  output logic             mwreg,
  output logic             mm2reg,
  output logic [REG_W-1:0] wdestReg,
  output logic             wwreg,
  output logic             wm2reg,
  output logic             stall,
  output logic             pc_we,
  output logic             ifid_we,
  output logic [CNT_W-1:0] retire_cnt
);

  logic [REG_W-1:0] ddest_c;
  logic             dw_c;
  logic             uses_rt_c;
  logic             stall_c;

  logic [REG_W-1:0] e_dest_q, e_dest_d;
  logic             e_wreg_q, e_wreg_d;
  logic             e_m2reg_q, e_m2reg_d;
  logic             e_valid_q, e_valid_d;

  logic [REG_W-1:0] m_dest_q, m_dest_d;
  logic             m_wreg_q, m_wreg_d;
  logic             m_m2reg_q, m_m2reg_d;
  logic             m_valid_q, m_valid_d;

  logic [REG_W-1:0] w_dest_q, w_dest_d;
  logic             w_wreg_q, w_wreg_d;
  logic             w_m2reg_q, w_m2reg_d;
  logic             w_valid_q, w_valid_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // ID decode: destination select, $0 write suppression, rt usage, load-use hazard
  always_comb begin
    ddest_c   = dregrt ? drt : drd;
    dw_c      = dvalid & dwreg & (ddest_c != '0);
    uses_rt_c = ~dregrt | dwmem;
    stall_c   = dvalid & e_wreg_q & e_m2reg_q & (e_dest_q != '0) &
                ((e_dest_q == drs) | (uses_rt_c & (e_dest_q == drt)));
  end

  // Next-state: EX takes ID or a bubble, MEM/WB shift freely, counter saturates
  always_comb begin
    e_dest_d  = '0;
    e_wreg_d  = 1'b0;
    e_m2reg_d = 1'b0;
    e_valid_d = 1'b0;
    if (dvalid && !stall_c) begin
      e_dest_d  = ddest_c;
      e_wreg_d  = dw_c;
      e_m2reg_d = dm2reg;
      e_valid_d = 1'b1;
    end

    m_dest_d  = e_dest_q;
    m_wreg_d  = e_wreg_q;
    m_m2reg_d = e_m2reg_q;
    m_valid_d = e_valid_q;

    w_dest_d  = m_dest_q;
    w_wreg_d  = m_wreg_q;
    w_m2reg_d = m_m2reg_q;
    w_valid_d = m_valid_q;

    cnt_d = cnt_q;
    if (w_valid_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Pipeline and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      e_dest_q  <= '0;
      e_wreg_q  <= 1'b0;
      e_m2reg_q <= 1'b0;
      e_valid_q <= 1'b0;
      m_dest_q  <= '0;
      m_wreg_q  <= 1'b0;
      m_m2reg_q <= 1'b0;
      m_valid_q <= 1'b0;
      w_dest_q  <= '0;
      w_wreg_q  <= 1'b0;
      w_m2reg_q <= 1'b0;
      w_valid_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      e_dest_q  <= e_dest_d;
      e_wreg_q  <= e_wreg_d;
      e_m2reg_q <= e_m2reg_d;
      e_valid_q <= e_valid_d;
      m_dest_q  <= m_dest_d;
      m_wreg_q  <= m_wreg_d;
      m_m2reg_q <= m_m2reg_d;
      m_valid_q <= m_valid_d;
      w_dest_q  <= w_dest_d;
      w_wreg_q  <= w_wreg_d;
      w_m2reg_q <= w_m2reg_d;
      w_valid_q <= w_valid_d;
      cnt_q     <= cnt_d;
    end
  end

  assign edestReg   = e_dest_q;
  assign ewreg      = e_wreg_q;
  assign em2reg     = e_m2reg_q;
  assign mdestReg   = m_dest_q;
  assign mwreg      = m_wreg_q;
  assign mm2reg     = m_m2reg_q;
  assign wdestReg   = w_dest_q;
  assign wwreg      = w_wreg_q;
  assign wm2reg     = w_m2reg_q;
  assign stall      = stall_c;
  assign pc_we      = ~stall_c;
  assign ifid_we    = ~stall_c;
  assign retire_cnt = cnt_q;

endmodule

// File: doc/pipe_dest_tracker.md
Name: pipe_dest_tracker

Overview:
- Producer side of the pipeline forwarding/hazard interface. Carries each ID-stage instruction's destination register, register-write flag and memory-to-register flag through the EX, MEM and WB pipeline registers.
- Publishes the per-stage values the decode/forwarding logic compares against.
- Detects load-use hazards, generates the stall and bubble, and counts retired instructions.

Parameters:
- REG_W, 5, register-index width.
- CNT_W, 16, retired-instruction counter width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- dvalid  input  1  ID stage holds a real instruction.
- dwreg  input  1  ID-decoded register-write enable.
- dm2reg  input  1  ID-decoded memory-to-register (load).
- dwmem  input  1  ID-decoded memory write (store); the store reads rt.
- dregrt  input  1  destination select: 1 = rt, 0 = rd.
- drs  input  REG_W  ID rs field.
- drt  input  REG_W  ID rt field.
- drd  input  REG_W  ID rd field.
- edestReg  output  REG_W  EX-stage destination register.
- ewreg  output  1  EX-stage write enable.
- em2reg  output  1  EX-stage load flag.
- mdestReg  output  REG_W  MEM-stage destination register.
- mwreg  output  1  MEM-stage write enable.
- mm2reg  output  1  MEM-stage load flag.
- wdestReg  output  REG_W  WB-stage destination register.
- wwreg  output  1  WB-stage write enable.
- wm2reg  output  1  WB-stage load flag.
- stall  output  1  load-use hazard; combinational.
- pc_we  output  1  PC write enable, equal to ~stall.
- ifid_we  output  1  IF/ID register write enable, equal to ~stall.
- retire_cnt  output  CNT_W  count of instructions that have left WB.

Behaviour:
- Clock and reset: one clock domain, clk, rising edge. Reset is synchronous and active-high on port reset. All state updates on rising clk only.
- Reset values: all dest, wreg, m2reg and stage-valid bits are 0 and retire_cnt is 0 in the cycle after the edge where reset=1. stall, pc_we and ifid_we then evaluate from cleared state, so stall=0 and pc_we=ifid_we=1 with dvalid=0.
- Destination mux (combinational): ddest = dregrt ? drt : drd.
- Write qualification: dw = dvalid & dwreg & (ddest != 0). Writes to $0 are never published as writes.
- uses_rt = ~dregrt | dwmem. R-types and stores read rt; loads and I-types do not.
- stall = dvalid & ewreg & em2reg & (edestReg != 0) & ((edestReg == drs) | (uses_rt & (edestReg == drt))).
- EX register update each edge:
  - If stall=1 or dvalid=0, load a bubble: dest=0, wreg=0, m2reg=0, valid=0.
  - Otherwise load dest=ddest, wreg=dw, m2reg=dvalid&dm2reg, valid=1.
- MEM register <= EX register, and WB register <= MEM register, unconditionally every edge. No back-pressure downstream of ID.
- Latency: an instruction accepted at edge N appears on the E outputs after N, on M after N+1, and on W after N+2.
- Stall duration: at most 1 cycle per load. The edge that inserts the bubble moves the load to MEM, so stall falls in the following cycle with unchanged ID inputs. A dependent instruction then forwards from the MEM stage.
- Counter: retire_cnt increments by 1 on each edge where the WB-stage valid bit is 1. It saturates at all-ones and does not wrap.
- Simultaneous events:
  - reset=1 overrides stall, dvalid and counter increment.
  - A stall coinciding with a retirement still increments the counter.
- Reset mid-operation: every in-flight instruction is discarded without being counted.
- No X propagation: every output is defined after the first reset edge.

Test Plan:
- Reset: reset=1 for 2 edges with random inputs -> all E/M/W outputs 0, retire_cnt=0, stall=0, pc_we=1.
- Pipeline flow: ADD rd=3 (dregrt=0, dwreg=1) at edge 1 -> edestReg=3 and ewreg=1 after edge 1; mdestReg=3 after edge 2; wdestReg=3 after edge 3; retire_cnt=1 after edge 4.
- $0 suppression: LW rt=0, dregrt=1 -> edestReg=0, ewreg=0; the next instruction with rs=0 gives stall=0.
- Load-use stall: LW rt=5, then SUB rs=5 held in ID -> stall=1 for exactly one cycle; the E outputs show a bubble (0/0/0); mdestReg=5, mm2reg=1; the next cycle has stall=0 and SUB enters EX.
- Store and I-type rt rules:
  - LW rt=7 then SW rt=7, rs=2 -> stall=1.
  - LW rt=7 then LW rt=7, rs=2 (dregrt=1, dwmem=0) -> stall=0.
- Saturation and mid-run reset:
  - With CNT_W=4, 20 back-to-back ADDs -> retire_cnt stops at 15.
  - Asserting reset with 3 instructions in flight -> retire_cnt=0, and no later increment from those instructions.
